// File: rtl/borrow_skip_subtractor_pipe_pkg.sv
// Shared arithmetic helpers: block partitioning for the skip-style pipelines.
package arith_pkg;

  function automatic int num_blocks(input int n, input int block_size);
    return (n + block_size - 1) / block_size;
  endfunction

  // The last block is narrower when n is not a multiple of block_size.
  function automatic int block_width(input int k, input int n, input int block_size);
    int hi;
    hi = (k + 1) * block_size;
    if (hi > n) hi = n;
    return hi - k * block_size;
  endfunction

endpackage

// File: rtl/borrow_skip_subtractor_pipe_block.sv
// One borrow-skip block: ripple borrow for the local result, skip mux for the
// block borrow out when every bit propagates.
module borrow_skip_block #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] diff,
  output logic         bout
);

  logic [W:0]   br;
  logic [W-1:0] p;
  logic         skip;

  always_comb begin
    br[0] = bin;
    for (int i = 0; i < W; i++) begin
      p[i]      = ~(a[i] ^ b[i]);
      diff[i]   = a[i] ^ b[i] ^ br[i];
      br[i + 1] = (~a[i] & b[i]) | (p[i] & br[i]);
    end
    skip = &p;
    bout = skip ? bin : br[W];
  end

endmodule

// File: rtl/borrow_skip_subtractor_pipe.sv
// Pipelined a - b - bin, one borrow-skip block per stage, valid/ready on both
// sides with a global stall that freezes every stage.
module borrow_skip_subtractor_pipe
  import arith_pkg::*;
#(
  parameter int N          = 8,
  parameter int BLOCK_SIZE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         ovf
);

  localparam int NB = num_blocks(N, BLOCK_SIZE);

  // Stage k registers feed block k; operands travel whole, diff fills in low to high.
  logic [NB-1:0][N-1:0] a_s;
  logic [NB-1:0][N-1:0] b_s;
  logic [NB-1:0][N-1:0] d_s;
  logic [NB-1:0][N-1:0] d_nx;
  logic [NB-1:0]        br_s;
  logic [NB-1:0]        br_nx;
  logic [NB-1:0]        v_s;
  logic                 stall;
  logic                 ovf_nx;
  logic                 unused_ops;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  generate
    for (genvar k = 0; k < NB; k++) begin : gen_stage
      localparam int LO = k * BLOCK_SIZE;
      localparam int W  = block_width(k, N, BLOCK_SIZE);
      localparam logic [N-1:0] MASK = N'({W{1'b1}}) << LO;

      logic [W-1:0] blk_diff;
      logic         blk_bout;

      borrow_skip_block #(.W(W)) u_blk (
        .a    (a_s[k][LO +: W]),
        .b    (b_s[k][LO +: W]),
        .bin  (br_s[k]),
        .diff (blk_diff),
        .bout (blk_bout)
      );

      assign d_nx[k]  = (d_s[k] & ~MASK) | (N'(blk_diff) << LO);
      assign br_nx[k] = blk_bout;
    end
  endgenerate

  assign ovf_nx = (a_s[NB-1][N-1] ^ b_s[NB-1][N-1]) &
                  (a_s[NB-1][N-1] ^ d_nx[NB-1][N-1]);

  // Low operand bits of the last stage are already consumed.
  assign unused_ops = ^{a_s[NB-1], b_s[NB-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_s       <= '0;
      b_s       <= '0;
      d_s       <= '0;
      br_s      <= '0;
      v_s       <= '0;
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (!stall) begin
      v_s[0] <= in_valid;
      if (in_valid) begin
        a_s[0]  <= a;
        b_s[0]  <= b;
        d_s[0]  <= '0;
        br_s[0] <= bin;
      end
      for (int k = 1; k < NB; k++) begin
        v_s[k] <= v_s[k-1];
        if (v_s[k-1]) begin
          a_s[k]  <= a_s[k-1];
          b_s[k]  <= b_s[k-1];
          d_s[k]  <= d_nx[k-1];
          br_s[k] <= br_nx[k-1];
        end
      end
      out_valid <= v_s[NB-1];
      if (v_s[NB-1]) begin
        diff <= d_nx[NB-1];
        bout <= br_nx[NB-1];
        ovf  <= ovf_nx;
      end
    end
  end

endmodule
